// File: rtl/sequence_generator_fsm.sv
// Serial pattern generator: parallel word in over valid/ready, MSB-first bit stream out,
// with GAP idle bit-times between words. SEQGEN_LOOP_EN repeats the last accepted word.
module sequence_generator_fsm #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned GAP      = 0,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             out_o,
  output logic             out_valid_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned   CW       = $clog2(WIDTH);
  localparam int unsigned   GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [GW-1:0]    gcnt, gcnt_nx;
  logic             boundary;
  logic             accept;

`ifdef SEQGEN_LOOP_EN
  logic [WIDTH-1:0] held;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i)     held <= '0;
    else if (accept) held <= data_i;
  end
`endif

  // A boundary is any cycle after which the next word may start without a bubble.
  always_comb begin
    boundary = 1'b0;
    case (state)
      S_IDLE:  boundary = 1'b1;
      S_SHIFT: boundary = (GAP == 0) && (cnt == '0);
      S_GAP:   boundary = (gcnt == '0);
      default: boundary = 1'b0;
    endcase
  end

  assign ready_o = boundary && !reset_i;
  assign accept  = valid_i && ready_o;

  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    gcnt_nx  = gcnt;
    if (accept) begin
      state_nx = S_SHIFT;
      sreg_nx  = data_i;
      cnt_nx   = CNT_LAST;
    end else if (boundary && (state != S_IDLE)) begin
`ifdef SEQGEN_LOOP_EN
      state_nx = S_SHIFT;
      sreg_nx  = held;
      cnt_nx   = CNT_LAST;
`else
      state_nx = S_IDLE;
`endif
    end else begin
      case (state)
        S_SHIFT: begin
          if (cnt != '0) begin
            sreg_nx = sreg << 1;
            cnt_nx  = cnt - 1'b1;
          end else begin
            state_nx = S_GAP;
            gcnt_nx  = GAP_LAST;
          end
        end
        S_GAP:   gcnt_nx = gcnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state       <= S_IDLE;
      sreg        <= '0;
      cnt         <= '0;
      gcnt        <= '0;
      out_o       <= IDLE_BIT;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state       <= state_nx;
      sreg        <= sreg_nx;
      cnt         <= cnt_nx;
      gcnt        <= gcnt_nx;
      out_o       <= (state_nx == S_SHIFT) ? sreg_nx[WIDTH-1] : IDLE_BIT;
      out_valid_o <= (state_nx == S_SHIFT);
      busy_o      <= (state_nx != S_IDLE);
      done_o      <= (state_nx == S_SHIFT) && (cnt_nx == '0);
    end
  end

endmodule

// File: tb/tb_sequence_generator_fsm.sv
// Bench for sequence_generator_fsm: two instances (GAP=0/IDLE_BIT=0 and GAP=2/IDLE_BIT=1)
// checked against a queue-of-future-bits reference model, plus vector table and directed cases.
module tb_sequence_generator_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [3:0] d0 = '0, d1 = '0;
  logic       r0, o0, ov0, b0, dn0;
  logic       r1, o1, ov1, b1, dn1;
  bit         chk_en = 1'b0;
  int         n_run = 0;
  int         n_fail = 0;

`ifdef SEQGEN_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  always #5 clk = ~clk;

  sequence_generator_fsm #(.WIDTH(4), .GAP(0), .IDLE_BIT(1'b0)) dut0 (
    .clk(clk), .reset_i(rst), .data_i(d0), .valid_i(v0), .ready_o(r0),
    .out_o(o0), .out_valid_o(ov0), .busy_o(b0), .done_o(dn0));

  sequence_generator_fsm #(.WIDTH(4), .GAP(2), .IDLE_BIT(1'b1)) dut1 (
    .clk(clk), .reset_i(rst), .data_i(d1), .valid_i(v1), .ready_o(r1),
    .out_o(o1), .out_valid_o(ov1), .busy_o(b1), .done_o(dn1));

  // Model: each instance keeps a queue of the output records for the cycles still to come.
  typedef struct packed {logic b; logic v; logic d; logic busy;} rec_t;
  rec_t       q[2][$];
  rec_t       cur[2];
  logic [3:0] held[2];
  bit         have[2];

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic rec_t idle_rec(input int i, input logic busy);
    return rec_t'({(i == 0) ? 1'b0 : 1'b1, 1'b0, 1'b0, busy});
  endfunction

  task automatic push_word(input int i, input logic [3:0] w);
    for (int k = 3; k >= 0; k--) q[i].push_back(rec_t'({w[k], 1'b1, (k == 0), 1'b1}));
    for (int g = 0; g < gap_of(i); g++) q[i].push_back(idle_rec(i, 1'b1));
  endtask

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        q[i].delete();
        cur[i]  = idle_rec(i, 1'b0);
        have[i] = 1'b0;
      end else begin
        if (((i == 0) ? v0 : v1) && q[i].size() == 0) begin
          held[i] = (i == 0) ? d0 : d1;
          have[i] = 1'b1;
          push_word(i, held[i]);
        end else if (LOOP && have[i] && q[i].size() == 0) begin
          push_word(i, held[i]);
        end
        cur[i] = (q[i].size() > 0) ? q[i].pop_front() : idle_rec(i, 1'b0);
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] obs(input int i);
    return (i == 0) ? {r0, o0, ov0, b0, dn0} : {r1, o1, ov1, b1, dn1};
  endfunction

  task automatic check_all(input int i);
    logic [4:0] a, e;
    string fn[5];
    fn = '{"done", "busy", "out_valid", "out", "ready"};
    a = obs(i);
    e = {!rst && (q[i].size() == 0), cur[i].b, cur[i].v, cur[i].busy, cur[i].d};
    for (int k = 0; k < 5; k++) chk($sformatf("model_%s[%0d]", fn[k], i), 16'(a[k]), 16'(e[k]));
  endtask

  always @(negedge clk) if (chk_en) for (int i = 0; i < 2; i++) check_all(i);

  task automatic do_reset();
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
  endtask

  typedef struct {logic v; logic [3:0] d; logic [4:0] e;} vec_t; // e = {ready,out,out_valid,busy,done}
  vec_t tab[14];

  logic [15:0] seq_o, seq_v, seq_d;
  int          ndone;

  initial begin
    tab[0]  = '{1'b1, 4'b1011, 5'b01110};
    tab[1]  = '{1'b0, 4'b0000, 5'b00110};
    tab[2]  = '{1'b0, 4'b0000, 5'b01110};
    tab[3]  = '{1'b0, 4'b0000, 5'b11111};
    tab[4]  = '{1'b0, 4'b0000, 5'b10000};
    tab[5]  = '{1'b1, 4'b1011, 5'b01110};
    tab[6]  = '{1'b1, 4'b0110, 5'b00110};
    tab[7]  = '{1'b1, 4'b0110, 5'b01110};
    tab[8]  = '{1'b1, 4'b0110, 5'b11111};
    tab[9]  = '{1'b1, 4'b0110, 5'b00110};
    tab[10] = '{1'b0, 4'b0000, 5'b01110};
    tab[11] = '{1'b0, 4'b0000, 5'b01110};
    tab[12] = '{1'b0, 4'b0000, 5'b10111};
    tab[13] = '{1'b0, 4'b0000, 5'b10000};

    // Asynchronous reset while the clock runs, before any edge has been seen.
    #2 rst = 1'b1;
    #1;
    chk("rst_out0", 16'(o0), 16'(1'b0));
    chk("rst_out1", 16'(o1), 16'(1'b1));
    chk("rst_flags0", 16'({r0, ov0, b0, dn0}), 16'h0);
    chk("rst_flags1", 16'({r1, ov1, b1, dn1}), 16'h0);
    @(negedge clk); #1 rst = 1'b0;
    chk_en = 1'b1;

`ifndef SEQGEN_LOOP_EN
    for (int i = 0; i < 14; i++) begin
      v0 = tab[i].v; d0 = tab[i].d;
      @(negedge clk);
      chk($sformatf("tab%0d", i), 16'(obs(0)), 16'(tab[i].e));
      #1;
    end
    v0 = 1'b0;
`endif

    // Gap instance: two 1111 words separated by two idle bit-times.
    do_reset();
    v1 = 1'b1; d1 = 4'b1111;
    seq_v = '0; seq_d = '0; seq_o = '0;
    for (int s = 1; s <= 10; s++) begin
      @(negedge clk);
      seq_v = {seq_v[14:0], ov1}; seq_d = {seq_d[14:0], dn1}; seq_o = {seq_o[14:0], o1};
      #1 if (s == 7) v1 = 1'b0;
    end
    chk("gap_valid", seq_v, 16'b1111001111);
    chk("gap_done", seq_d, 16'b0001000001);
    chk("gap_out", seq_o, 16'b1111111111);

    // Reset after two bits: no done pulse, then a clean new word.
    do_reset();
    v0 = 1'b1; d0 = 4'b1011;
    @(negedge clk); #1 v0 = 1'b0; d0 = 4'b0000;
    @(negedge clk); #1 rst = 1'b1;
    #1;
    chk("mid_rst_out", 16'({o0, ov0, b0, dn0, r0}), 16'h0);
    @(negedge clk);
    chk("mid_rst_hold", 16'({o0, ov0, b0, dn0, r0}), 16'h0);
    #1 rst = 1'b0; v0 = 1'b1; d0 = 4'b0110;
    seq_o = '0; seq_v = '0; seq_d = '0;
    for (int s = 1; s <= 4; s++) begin
      @(negedge clk);
      seq_o = {seq_o[14:0], o0}; seq_v = {seq_v[14:0], ov0}; seq_d = {seq_d[14:0], dn0};
      #1 v0 = 1'b0;
    end
    chk("post_rst_out", seq_o, 16'b0110);
    chk("post_rst_valid", seq_v, 16'b1111);
    chk("post_rst_done", seq_d, 16'b0001);

`ifdef SEQGEN_LOOP_EN
    do_reset();
    v0 = 1'b1; d0 = 4'b1001;
    seq_o = '0; ndone = 0;
    for (int s = 1; s <= 12; s++) begin
      @(negedge clk);
      seq_o = {seq_o[14:0], o0}; ndone += int'(dn0);
      #1 v0 = 1'b0;
    end
    chk("loop_out", seq_o, 16'b100110011001);
    chk("loop_done", 16'(ndone), 16'd3);
    v0 = 1'b1; d0 = 4'b0011;
    seq_o = '0;
    for (int s = 1; s <= 8; s++) begin
      @(negedge clk);
      seq_o = {seq_o[14:0], o0};
      #1 v0 = 1'b0;
    end
    chk("loop_replace", seq_o, 16'b00110011);
    do_reset();
`endif

    // Randomized traffic on both instances, with occasional mid-cycle resets.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk); #1;
      rst = (($urandom % 50) == 0);
      v0 = (($urandom % 3) != 0); d0 = 4'($urandom);
      v1 = (($urandom % 3) != 0); d1 = 4'($urandom);
    end
    @(negedge clk); #1 rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    repeat (8) @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/sequence_generator_fsm.md
# sequence_generator_fsm

Serial pattern generator: accepts a parallel WIDTH-bit word over a valid/ready handshake and emits it MSB-first, one bit per clock, on a single serial line. This is the transmit-side counterpart of the team's serial sequence detector. It drives detector stimulus and in-system loopback, and it inserts a programmable number of idle bits between words.

## Interface
- WIDTH, 4: bits per word; legal values are 2 and above.
- GAP, 0: idle bit-times inserted after each word; legal values are 0 and above.
- IDLE_BIT, 1'b0: level driven on out_o when no word bit is being sent.

- clk  input  1  rising-edge clock.
- reset_i  input  1  asynchronous reset, active-high.
- data_i  input  WIDTH  word to send; bit WIDTH-1 goes first.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  block accepts data_i this cycle.
- out_o  output  1  serial bit, registered.
- out_valid_o  output  1  out_o carries a word bit, registered.
- busy_o  output  1  state is not IDLE, registered.
- done_o  output  1  one-cycle pulse on the last bit of a word, registered.

## Operation
- States: IDLE, SHIFT, GAP.
- A handshake completes on a rising edge where valid_i=1 and ready_o=1. On that edge:
  - data_i is captured into the shift register.
  - The bit counter loads WIDTH-1.
  - The state goes to SHIFT.
- SHIFT:
  - out_o is the shift-register MSB and out_valid_o=1.
  - The register shifts left each cycle; the counter decrements.
  - At count 0, done_o=1 for that cycle.
  - Next state: GAP if GAP>0. If GAP=0, next state is SHIFT when a handshake completes that cycle, otherwise IDLE.
- GAP:
  - out_o=IDLE_BIT and out_valid_o=0 for exactly GAP cycles.
  - The gap counter has width $clog2(GAP+1).
  - After the final gap cycle: SHIFT if a handshake completes, otherwise IDLE.
- IDLE: out_o=IDLE_BIT, out_valid_o=0, busy_o=0.
- ready_o is combinational from state and counters. It is 1 in these cases and 0 in every other case:
  - in IDLE;
  - on the final SHIFT bit when GAP=0;
  - on the final GAP cycle.
- ready_o is forced to 0 while reset_i=1.
- valid_i while ready_o=0 is ignored. Data is neither captured nor queued. The upstream block must hold valid_i.
- Bit counter width is $clog2(WIDTH). The counter never wraps below 0.

## Timing
- Reset values:
  - state=IDLE, out_o=IDLE_BIT, out_valid_o=0, busy_o=0, done_o=0, ready_o=0.
  - Shift register and counters are cleared.
- Latency: the first bit (data_i[WIDTH-1]) appears on out_o in the cycle after the accepting edge.
- A word occupies WIDTH cycles, then GAP cycles.
- Throughput: one word per WIDTH+GAP cycles. With GAP=0 there are no idle bits between back-to-back words.
- done_o is asserted in the same cycle as the last out_o bit of each word.
- Reset asserted mid-word:
  - All outputs go to their reset values immediately, without waiting for clk.
  - The partial word is discarded.
  - No done_o pulse is produced.
- On reset release, the block starts in IDLE. The first handshake is possible on the first rising edge with reset_i=0.
- A handshake on the final bit or final gap cycle makes the new word's first bit follow in the next cycle, with no bubble.

## Configuration
- Macro: SEQGEN_LOOP_EN.
- Defined:
  - At a word boundary where the block would go to IDLE (no handshake), it instead reloads the last accepted word and re-enters SHIFT.
  - The word repeats indefinitely.
  - ready_o stays asserted at each boundary, so a new word replaces the held one.
  - busy_o stays 1 until reset.
- Undefined: the block returns to IDLE after each word, as described above.

## Test plan
- Reset: assert reset_i mid-cycle with clk running. Required: out_o=IDLE_BIT, out_valid_o=0, busy_o=0, done_o=0, ready_o=0 asynchronously.
- Single word, WIDTH=4, GAP=0: send data_i=4'b1011 with one valid_i pulse.
  - out_o=1,0,1,1 on cycles 1–4 after acceptance, with out_valid_o=1 throughout.
  - done_o=1 on cycle 4 only; IDLE on cycle 5.
  - Feeding out_o into the 1011 detector gives exactly one detection.
- Back-to-back, GAP=0: send 4'b1011 then 4'b0110 with valid_i held. Required: 8 contiguous valid bits 1,0,1,1,0,1,1,0 and two done_o pulses.
- Gap, GAP=2: send 4'b1111 twice. Required: bits 1,1,1,1, then two cycles of IDLE_BIT with out_valid_o=0, then 1,1,1,1.
- Busy ignore and reset mid-word:
  - Change data_i while ready_o=0; the transmitted word is unchanged.
  - Assert reset_i after bit 2; no done_o pulse, and the next word starts cleanly.
- Loop, with SEQGEN_LOOP_EN: send 4'b1001 once.
  - Required: 1,0,0,1 repeating for at least 3 words, with a done_o pulse per word.
  - A new handshake with 4'b0011 takes effect at the next word boundary.
